// File: rtl/lc3_control_fsm.sv
// rtl/lc3_control_fsm.sv - LC-3 Moore control FSM with programmable SRAM wait cycles
// Drives datapath load strobes, bus gates, mux selects, ALUK and memory strobes.
module lc3_control_fsm #(
    parameter int MEM_WAIT    = 2,
    parameter bit PAUSE_FETCH = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic       MIO_EN
);

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, PAUSE_IR1, PAUSE_IR2, S32,
        S01, S05, S09, S00, S22, S12, S04, S21, S20,
        S06, S25, S27, S07, S23, S16, PAUSE1, PAUSE2
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t     state;
    state_t     next_state;
    logic [2:0] wait_cnt;
    logic       in_wait;
    logic       wait_done;

    assign in_wait   = state inside {S33, S25, S16};
    assign wait_done = (wait_cnt == WAIT_LAST);
    assign MIO_EN    = ~Mem_OE;

    // Counter restarts at zero whenever a wait state is entered or left.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= HALTED;
            wait_cnt <= 3'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= (in_wait && next_state == state) ? wait_cnt + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        next_state = state;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        PCMUX      = 2'b00;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;

        case (state)
            HALTED: if (Run) next_state = S18;
            S18: begin
                GatePC     = 1'b1;
                LD_MAR     = 1'b1;
                LD_PC      = 1'b1;
                next_state = S33;
            end
            S33: begin
                Mem_OE = 1'b0;
                if (wait_done) begin
                    LD_MDR     = 1'b1;
                    next_state = S35;
                end
            end
            S35: begin
                GateMDR    = 1'b1;
                LD_IR      = 1'b1;
                next_state = PAUSE_FETCH ? PAUSE_IR1 : S32;
            end
            PAUSE_IR1: if (Continue) next_state = PAUSE_IR2;
            PAUSE_IR2: if (!Continue) next_state = S32;
            S32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    4'b0001: next_state = S01;
                    4'b0101: next_state = S05;
                    4'b1001: next_state = S09;
                    4'b0000: next_state = S00;
                    4'b1100: next_state = S12;
                    4'b0100: next_state = S04;
                    4'b0110: next_state = S06;
                    4'b0111: next_state = S07;
                    4'b1101: next_state = PAUSE1;
                    default: next_state = S18;
                endcase
            end
            S01, S05: begin
                SR1MUX     = 1'b1;
                SR2MUX     = IR_5;
                ALUK       = (state == S05) ? 2'b01 : 2'b00;
                GateALU    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                next_state = S18;
            end
            S09: begin
                SR1MUX     = 1'b1;
                ALUK       = 2'b10;
                GateALU    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                next_state = S18;
            end
            S00: next_state = BEN ? S22 : S18;
            S22: begin
                ADDR2MUX   = 2'b01;
                PCMUX      = 2'b10;
                LD_PC      = 1'b1;
                next_state = S18;
            end
            S12: begin
                SR1MUX     = 1'b1;
                ALUK       = 2'b11;
                GateALU    = 1'b1;
                PCMUX      = 2'b01;
                LD_PC      = 1'b1;
                next_state = S18;
            end
            S04: begin
                GatePC     = 1'b1;
                DRMUX      = 1'b1;
                LD_REG     = 1'b1;
                next_state = IR_11 ? S21 : S20;
            end
            S21: begin
                PCMUX      = 2'b10;
                LD_PC      = 1'b1;
                next_state = S18;
            end
            S20: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b11;
                PCMUX      = 2'b10;
                LD_PC      = 1'b1;
                next_state = S18;
            end
            // Base+offset6 address computation shared by LDR and STR.
            S06, S07: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b10;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                next_state = (state == S06) ? S25 : S23;
            end
            S25: begin
                Mem_OE = 1'b0;
                if (wait_done) begin
                    LD_MDR     = 1'b1;
                    next_state = S27;
                end
            end
            S27: begin
                GateMDR    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                next_state = S18;
            end
            S23: begin
                ALUK       = 2'b11;
                GateALU    = 1'b1;
                LD_MDR     = 1'b1;
                next_state = S16;
            end
            S16: begin
                Mem_WE = 1'b0;
                if (wait_done) next_state = S18;
            end
            PAUSE1: begin
                LD_LED = 1'b1;
                if (Continue) next_state = PAUSE2;
            end
            PAUSE2: begin
                LD_LED = 1'b1;
                if (!Continue) next_state = S18;
            end
            default: next_state = HALTED;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb/tb_lc3_control_fsm.sv - directed scoreboard bench for lc3_control_fsm
module tb_lc3_control_fsm;

    logic       Clk = 1'b0;
    logic       Reset, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       Mem_OE, Mem_WE, MIO_EN;

    lc3_control_fsm #(.MEM_WAIT(2), .PAUSE_FETCH(1'b0)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .MIO_EN(MIO_EN)
    );

    always #5 Clk = ~Clk;

    localparam logic [24:0] B_LD_MAR  = 25'd1 << 24;
    localparam logic [24:0] B_LD_MDR  = 25'd1 << 23;
    localparam logic [24:0] B_LD_IR   = 25'd1 << 22;
    localparam logic [24:0] B_LD_BEN  = 25'd1 << 21;
    localparam logic [24:0] B_LD_CC   = 25'd1 << 20;
    localparam logic [24:0] B_LD_REG  = 25'd1 << 19;
    localparam logic [24:0] B_LD_PC   = 25'd1 << 18;
    localparam logic [24:0] B_LD_LED  = 25'd1 << 17;
    localparam logic [24:0] B_G_PC    = 25'd1 << 16;
    localparam logic [24:0] B_G_MDR   = 25'd1 << 15;
    localparam logic [24:0] B_G_ALU   = 25'd1 << 14;
    localparam logic [24:0] B_G_MARM  = 25'd1 << 13;
    localparam logic [24:0] B_DRMUX   = 25'd1 << 12;
    localparam logic [24:0] B_SR1MUX  = 25'd1 << 11;
    localparam logic [24:0] B_SR2MUX  = 25'd1 << 10;
    localparam logic [24:0] B_A1MUX   = 25'd1 << 9;
    localparam logic [24:0] B_PC_BUS  = 25'd1 << 7;
    localparam logic [24:0] B_PC_ADD  = 25'd2 << 7;
    localparam logic [24:0] B_A2_01   = 25'd1 << 5;
    localparam logic [24:0] B_A2_10   = 25'd2 << 5;
    localparam logic [24:0] B_A2_11   = 25'd3 << 5;
    localparam logic [24:0] B_AND     = 25'd1 << 3;
    localparam logic [24:0] B_NOT     = 25'd2 << 3;
    localparam logic [24:0] B_PASS    = 25'd3 << 3;
    localparam logic [24:0] B_OE      = 25'd1 << 2;
    localparam logic [24:0] B_WE      = 25'd1 << 1;
    localparam logic [24:0] B_MIO     = 25'd1;

    localparam logic [24:0] E_IDLE  = B_OE | B_WE;
    localparam logic [24:0] E_S18   = E_IDLE | B_G_PC | B_LD_MAR | B_LD_PC;
    localparam logic [24:0] E_READ  = B_WE | B_MIO;
    localparam logic [24:0] E_S35   = E_IDLE | B_G_MDR | B_LD_IR;
    localparam logic [24:0] E_S32   = E_IDLE | B_LD_BEN;
    localparam logic [24:0] E_ALU   = E_IDLE | B_SR1MUX | B_G_ALU | B_LD_REG | B_LD_CC;
    localparam logic [24:0] E_S22   = E_IDLE | B_A2_01 | B_PC_ADD | B_LD_PC;
    localparam logic [24:0] E_S12   = E_IDLE | B_SR1MUX | B_PASS | B_G_ALU | B_PC_BUS | B_LD_PC;
    localparam logic [24:0] E_S04   = E_IDLE | B_G_PC | B_DRMUX | B_LD_REG;
    localparam logic [24:0] E_S21   = E_IDLE | B_PC_ADD | B_LD_PC;
    localparam logic [24:0] E_S20   = E_IDLE | B_SR1MUX | B_A1MUX | B_A2_11 | B_PC_ADD | B_LD_PC;
    localparam logic [24:0] E_S06   = E_IDLE | B_SR1MUX | B_A1MUX | B_A2_10 | B_G_MARM | B_LD_MAR;
    localparam logic [24:0] E_S27   = E_IDLE | B_G_MDR | B_LD_REG | B_LD_CC;
    localparam logic [24:0] E_S23   = E_IDLE | B_PASS | B_G_ALU | B_LD_MDR;
    localparam logic [24:0] E_WRITE = B_OE;
    localparam logic [24:0] E_PAUSE = E_IDLE | B_LD_LED;

    int checks = 0;
    int errors = 0;
    logic [24:0] exp_q[$];
    logic [24:0] got;

    assign got = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
                  PCMUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE, MIO_EN};

    task automatic chk(input string tag, input logic [24:0] e);
        logic [24:0] x;
        logic        inv;
        exp_q.push_back(e);
        @(negedge Clk);
        x = exp_q.pop_front();
        checks++;
        assert (got === x) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, x);
        end
        inv = ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1) &&
              (Mem_OE || Mem_WE) && (MIO_EN === ~Mem_OE);
        checks++;
        assert (inv === 1'b1) else begin
            errors++;
            $error("FAIL %s_invariant observed=%b expected=1", tag, inv);
        end
    endtask

    task automatic fetch(input string tag, input logic [3:0] op, input logic i5,
                         input logic i11, input logic b);
        Opcode = op;
        IR_5   = i5;
        IR_11  = i11;
        BEN    = b;
        chk({tag, "_s33a"}, E_READ);
        chk({tag, "_s33b"}, E_READ);
        chk({tag, "_s33c"}, E_READ | B_LD_MDR);
        chk({tag, "_s35"}, E_S35);
        chk({tag, "_s32"}, E_S32);
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
        Opcode = 4'b0000; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        chk("reset", E_IDLE);
        Reset = 1'b0;
        chk("halt_hold", E_IDLE);
        Run = 1'b1;
        chk("run_s18", E_S18);
        Run = 1'b0;
        chk("mid_s33a", E_READ);
        chk("mid_s33b", E_READ);
        Reset = 1'b1;
        chk("mid_reset", E_IDLE);
        Reset = 1'b0; Run = 1'b1;
        chk("rerun_s18", E_S18);

        fetch("add_imm", 4'b0001, 1'b1, 1'b0, 1'b0);
        Run = 1'b0;
        chk("add_imm_s01", E_ALU | B_SR2MUX);
        chk("add_imm_s18", E_S18);
        fetch("add_reg", 4'b0001, 1'b0, 1'b0, 1'b0);
        chk("add_reg_s01", E_ALU);
        chk("add_reg_s18", E_S18);
        fetch("and_imm", 4'b0101, 1'b1, 1'b0, 1'b0);
        chk("and_s05", E_ALU | B_SR2MUX | B_AND);
        chk("and_s18", E_S18);
        fetch("not", 4'b1001, 1'b0, 1'b0, 1'b0);
        chk("not_s09", E_ALU | B_NOT);
        chk("not_s18", E_S18);
        fetch("br_nt", 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("br_nt_s00", E_IDLE);
        chk("br_nt_s18", E_S18);
        fetch("br_t", 4'b0000, 1'b0, 1'b0, 1'b1);
        chk("br_t_s00", E_IDLE);
        chk("br_t_s22", E_S22);
        chk("br_t_s18", E_S18);
        fetch("jmp", 4'b1100, 1'b0, 1'b0, 1'b0);
        chk("jmp_s12", E_S12);
        chk("jmp_s18", E_S18);
        fetch("jsr", 4'b0100, 1'b0, 1'b1, 1'b0);
        chk("jsr_s04", E_S04);
        chk("jsr_s21", E_S21);
        chk("jsr_s18", E_S18);
        fetch("jsrr", 4'b0100, 1'b0, 1'b0, 1'b0);
        chk("jsrr_s04", E_S04);
        chk("jsrr_s20", E_S20);
        chk("jsrr_s18", E_S18);
        fetch("ldr", 4'b0110, 1'b0, 1'b0, 1'b0);
        chk("ldr_s06", E_S06);
        chk("ldr_s25a", E_READ);
        chk("ldr_s25b", E_READ);
        chk("ldr_s25c", E_READ | B_LD_MDR);
        chk("ldr_s27", E_S27);
        chk("ldr_s18", E_S18);
        fetch("str", 4'b0111, 1'b0, 1'b0, 1'b0);
        chk("str_s07", E_S06);
        chk("str_s23", E_S23);
        chk("str_s16a", E_WRITE);
        chk("str_s16b", E_WRITE);
        chk("str_s16c", E_WRITE);
        chk("str_s18", E_S18);
        fetch("pause", 4'b1101, 1'b0, 1'b0, 1'b0);
        chk("pause1a", E_PAUSE);
        chk("pause1b", E_PAUSE);
        Continue = 1'b1;
        chk("pause2a", E_PAUSE);
        chk("pause2b", E_PAUSE);
        Continue = 1'b0;
        chk("pause_s18", E_S18);
        fetch("nop", 4'b1111, 1'b0, 1'b0, 1'b0);
        chk("nop_s18", E_S18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
